blood_fx_ctrl: RTL

Sequencer and sharer for the 64x64, 12-bit blood-splatter sprite ROMs. It holds one animated effect slot per player and steps each effect through its ROM frames on video frame ticks. For every scanned pixel it picks at most one effect and drives the shared ROM row/col and frame select. It returns a registered, transparency-keyed pixel to the VGA mixer.

---
 rtl/blood_fx_pkg.sv | 24 ++
 rtl/blood_fx_ctrl_if.sv | 45 ++++
 rtl/blood_fx_slot.sv | 104 ++++++++++
 rtl/blood_fx_ctrl.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/blood_fx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : blood_fx_pkg
// Description : Shared constants, slot state encoding and helper for blood_fx
// Revision    : 1.0
// ============================================================================
package blood_fx_pkg;

    localparam int          SPR         = 64;
    localparam int          HALF        = 32;
    localparam logic [11:0] TRANSPARENT = 12'h000;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } slot_state_e;

    // Sprite top-left from its centre; may go negative near the screen edge.
    function automatic logic signed [10:0] sprite_origin(input logic [9:0] c);
        return $signed({1'b0, c}) - $signed(11'(HALF));
    endfunction

endpackage
`default_nettype wire

// File: rtl/blood_fx_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : blood_fx_ctrl_if
// Description : Request, scan, ROM and overlay signals of the blood_fx block
// Revision    : 1.0
// ============================================================================
interface blood_fx_ctrl_if #(
    parameter int N_FRAMES = 4
);
    localparam int FW = $clog2(N_FRAMES);

    logic          frame_tick;
    logic          video_on;
    logic [9:0]    pixel_x;
    logic [9:0]    pixel_y;
    logic [1:0]    hit_req;
    logic [9:0]    hit_x0;
    logic [9:0]    hit_y0;
    logic [9:0]    hit_x1;
    logic [9:0]    hit_y1;
    logic [1:0]    hit_ack;
    logic [1:0]    fx_busy;
    logic [5:0]    rom_row;
    logic [5:0]    rom_col;
    logic [FW-1:0] rom_frame;
    logic [11:0]   rom_data;
    logic          blood_on;
    logic [11:0]   blood_rgb;

    modport slave (
        input  frame_tick, video_on, pixel_x, pixel_y,
        input  hit_req, hit_x0, hit_y0, hit_x1, hit_y1, rom_data,
        output hit_ack, fx_busy, rom_row, rom_col, rom_frame,
        output blood_on, blood_rgb
    );

    modport master (
        output frame_tick, video_on, pixel_x, pixel_y,
        output hit_req, hit_x0, hit_y0, hit_x1, hit_y1, rom_data,
        input  hit_ack, fx_busy, rom_row, rom_col, rom_frame,
        input  blood_on, blood_rgb
    );

endinterface
`default_nettype wire

// File: rtl/blood_fx_slot.sv
`default_nettype none
// ============================================================================
// Module      : blood_fx_slot
// Description : One player's effect slot: FSM, position latch, frame counters,
//               hit test and registered acknowledge.
// Revision    : 1.0
// ============================================================================
module blood_fx_slot
    import blood_fx_pkg::*;
#(
    parameter int N_FRAMES   = 4,
    parameter int HOLD_TICKS = 6,
    localparam int FW        = $clog2(N_FRAMES),
    localparam int HW        = $clog2(HOLD_TICKS),
    localparam int AW        = $clog2(SPR)
) (
    input  wire logic          clk,
    input  wire logic          reset_n,
    input  wire logic          frame_tick_i,
    input  wire logic          video_on_i,
    input  wire logic [9:0]    pixel_x_i,
    input  wire logic [9:0]    pixel_y_i,
    input  wire logic          req_i,
    input  wire logic [9:0]    hit_x_i,
    input  wire logic [9:0]    hit_y_i,
    output      logic          ack_o,
    output      logic          busy_o,
    output      logic          inside_o,
    output      logic [AW-1:0] row_o,
    output      logic [AW-1:0] col_o,
    output      logic [FW-1:0] frame_o
);

    slot_state_e        state_q, state_d;
    logic signed [10:0] ox_q, ox_d;
    logic signed [10:0] oy_q, oy_d;
    logic [FW-1:0]      frame_q, frame_d;
    logic [HW-1:0]      hold_q, hold_d;
    logic               ack_q, ack_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ox_q    <= '0;
            oy_q    <= '0;
            frame_q <= '0;
            hold_q  <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ox_q    <= ox_d;
            oy_q    <= oy_d;
            frame_q <= frame_d;
            hold_q  <= hold_d;
            ack_q   <= ack_d;
        end
    end

    // A request (first trigger or retrigger) outranks a same-cycle tick.
    always_comb begin
        state_d = state_q;
        ox_d    = ox_q;
        oy_d    = oy_q;
        frame_d = frame_q;
        hold_d  = hold_q;
        ack_d   = req_i;
        if (req_i) begin
            state_d = ACTIVE;
            ox_d    = sprite_origin(hit_x_i);
            oy_d    = sprite_origin(hit_y_i);
            frame_d = '0;
            hold_d  = '0;
        end else if (state_q == ACTIVE && frame_tick_i) begin
            if (hold_q == HW'(HOLD_TICKS - 1)) begin
                hold_d = '0;
                if (frame_q == FW'(N_FRAMES - 1)) begin
                    state_d = IDLE;
                    frame_d = '0;
                end else begin
                    frame_d = frame_q + FW'(1);
                end
            end else begin
                hold_d = hold_q + HW'(1);
            end
        end
    end

    logic signed [11:0] w_dx;
    logic signed [11:0] w_dy;

    assign w_dx = $signed({2'b00, pixel_x_i}) - $signed({ox_q[10], ox_q});
    assign w_dy = $signed({2'b00, pixel_y_i}) - $signed({oy_q[10], oy_q});

    // Zero upper bits means 0 <= d < SPR, which also rejects negatives.
    assign inside_o = (state_q == ACTIVE) && video_on_i &&
                      (w_dx[11:AW] == '0) && (w_dy[11:AW] == '0);
    assign row_o    = w_dy[AW-1:0];
    assign col_o    = w_dx[AW-1:0];
    assign frame_o  = frame_q;
    assign ack_o    = ack_q;
    assign busy_o   = (state_q == ACTIVE);

endmodule
`default_nettype wire

// File: rtl/blood_fx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : blood_fx_ctrl
// Description : Two-slot blood-splatter sequencer, ROM sharer and overlay
//               pipeline. Define BLOOD_RR_EN for per-frame alternating
//               overlap priority; default is player 0 always wins.
// Revision    : 1.0
// ============================================================================
module blood_fx_ctrl
    import blood_fx_pkg::*;
#(
    parameter int N_FRAMES   = 4,
    parameter int HOLD_TICKS = 6
) (
    input wire logic       clk,
    input wire logic       reset_n,
    blood_fx_ctrl_if.slave bus
);

    localparam int FW = $clog2(N_FRAMES);

    logic [9:0]    w_hx     [2];
    logic [9:0]    w_hy     [2];
    logic [5:0]    w_row    [2];
    logic [5:0]    w_col    [2];
    logic [FW-1:0] w_frame  [2];
    logic [1:0]    w_ack;
    logic [1:0]    w_busy;
    logic [1:0]    w_inside;

    assign w_hx[0] = bus.hit_x0;
    assign w_hy[0] = bus.hit_y0;
    assign w_hx[1] = bus.hit_x1;
    assign w_hy[1] = bus.hit_y1;

    generate
        for (genvar p = 0; p < 2; p++) begin : g_slot
            blood_fx_slot #(
                .N_FRAMES   (N_FRAMES),
                .HOLD_TICKS (HOLD_TICKS)
            ) u_slot (
                .clk          (clk),
                .reset_n      (reset_n),
                .frame_tick_i (bus.frame_tick),
                .video_on_i   (bus.video_on),
                .pixel_x_i    (bus.pixel_x),
                .pixel_y_i    (bus.pixel_y),
                .req_i        (bus.hit_req[p]),
                .hit_x_i      (w_hx[p]),
                .hit_y_i      (w_hy[p]),
                .ack_o        (w_ack[p]),
                .busy_o       (w_busy[p]),
                .inside_o     (w_inside[p]),
                .row_o        (w_row[p]),
                .col_o        (w_col[p]),
                .frame_o      (w_frame[p])
            );
        end
    endgenerate

    logic w_sel0;
    logic w_sel1;

`ifdef BLOOD_RR_EN
    logic prio_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prio_q <= 1'b0;
        end else if (bus.frame_tick) begin
            prio_q <= ~prio_q;
        end
    end

    assign w_sel1 = w_inside[1] && (!w_inside[0] || prio_q);
`else
    assign w_sel1 = w_inside[1] && !w_inside[0];
`endif
    assign w_sel0 = w_inside[0] && !w_sel1;

    logic [5:0]    row_q, row_d;
    logic [5:0]    col_q, col_d;
    logic [FW-1:0] frame_q, frame_d;
    logic          v1_q, v1_d;
    logic          v2_q;
    logic          on_q, on_d;
    logic [11:0]   rgb_q, rgb_d;

    always_comb begin
        row_d   = '0;
        col_d   = '0;
        frame_d = '0;
        v1_d    = w_sel0 || w_sel1;
        if (w_sel0) begin
            row_d   = w_row[0];
            col_d   = w_col[0];
            frame_d = w_frame[0];
        end else if (w_sel1) begin
            row_d   = w_row[1];
            col_d   = w_col[1];
            frame_d = w_frame[1];
        end
    end

    // rom_data lines up with v2 because the ROM registers our address.
    always_comb begin
        on_d  = v2_q && (bus.rom_data != TRANSPARENT);
        rgb_d = on_d ? bus.rom_data : TRANSPARENT;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row_q   <= '0;
            col_q   <= '0;
            frame_q <= '0;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            on_q    <= 1'b0;
            rgb_q   <= '0;
        end else begin
            row_q   <= row_d;
            col_q   <= col_d;
            frame_q <= frame_d;
            v1_q    <= v1_d;
            v2_q    <= v1_q;
            on_q    <= on_d;
            rgb_q   <= rgb_d;
        end
    end

    assign bus.hit_ack   = w_ack;
    assign bus.fx_busy   = w_busy;
    assign bus.rom_row   = row_q;
    assign bus.rom_col   = col_q;
    assign bus.rom_frame = frame_q;
    assign bus.blood_on  = on_q;
    assign bus.blood_rgb = rgb_q;

endmodule
`default_nettype wire
